// File: rtl/usr_seq.sv
// Sequencing controller for the universal shift register: accepts one command at a
// time and drives the register's mode, serial inputs and load data until it completes.
module usr_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             fill,
  input  logic [WIDTH-1:0] q,
  output logic [1:0]       s,
  output logic             rs,
  output logic             ls,
  output logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_ILL  = 3'b111
  } op_t;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  state_t           state;
  op_t              op_r;
  logic [CNT_W-1:0] cnt_r;
  logic             fill_r;
  op_t              new_op;
  logic             new_right;

  assign new_op    = op_t'(cmd_op);
  assign new_right = (new_op == OP_SHR) || (new_op == OP_ROR) || (new_op == OP_ASR);

  // All handshake and register-control outputs are registered; the command is
  // captured in full at acceptance so later input changes cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_r      <= OP_NOP;
      cnt_r     <= '0;
      fill_r    <= 1'b0;
      s         <= S_HOLD;
      a         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          s    <= S_HOLD;
          if (cmd_valid && cmd_ready) begin
            op_r      <= new_op;
            cnt_r     <= cmd_cnt;
            fill_r    <= fill;
            a         <= cmd_data;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            case (new_op)
              OP_NOP: begin
                state <= DONE;
                done  <= 1'b1;
              end
              OP_LOAD: begin
                state <= LOAD;
                s     <= S_LOAD;
              end
              OP_ILL: begin
                state <= DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end
              default: begin
                if (cmd_cnt == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  state <= SHIFT;
                  s     <= new_right ? S_RIGHT : S_LEFT;
                end
              end
            endcase
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        LOAD: begin
          state <= DONE;
          s     <= S_HOLD;
          done  <= 1'b1;
        end

        // The count is loaded with N and the last shift cycle is the one that sees 1,
        // so the counter never reaches zero and cannot wrap.
        SHIFT: begin
          if (cnt_r == CNT_W'(1)) begin
            state <= DONE;
            s     <= S_HOLD;
            done  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end

        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: begin
          state <= IDLE;
          s     <= S_HOLD;
        end
      endcase
    end
  end

  // Serial feedback follows the live register contents so rotates and arithmetic
  // shifts see each intermediate value.
  always_comb begin
    rs = 1'b0;
    ls = 1'b0;
    if (state == SHIFT) begin
      case (op_r)
        OP_SHR:  ls = fill_r;
        OP_SHL:  rs = fill_r;
        OP_ROR:  ls = q[0];
        OP_ROL:  rs = q[WIDTH-1];
        OP_ASR:  ls = q[WIDTH-1];
        default: ;
      endcase
    end
  end

  logic unused_q;
  assign unused_q = ^q;

endmodule

// File: tb/tb_usr_seq.sv
// Bench for usr_seq: a behavioural shift register closes the loop, and each command's
// final value and timing are predicted arithmetically from the op, count and fill.
module tb_usr_seq;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic             fill = 1'b0;
  logic [WIDTH-1:0] usr_q = '0;
  logic [1:0]       s;
  logic             rs;
  logic             ls;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic             err;

  int num_checks = 0;
  int num_errors = 0;
  int model_q = 0;

  always #5 clk = ~clk;

  usr_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .fill(fill),
    .q(usr_q), .s(s), .rs(rs), .ls(ls), .a(a),
    .busy(busy), .done(done), .err(err)
  );

  // The attached register itself; it has no reset, so its contents survive rst.
  always @(posedge clk) begin
    case (s)
      2'b01:   usr_q <= {ls, usr_q[WIDTH-1:1]};
      2'b10:   usr_q <= {usr_q[WIDTH-2:0], rs};
      2'b11:   usr_q <= a;
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Result of a whole command computed in one step from the op semantics.
  function automatic int refResult(input int op, input int n, input int cur,
                                   input int data, input int fill_v);
    int r;
    int f;
    f = fill_v;
    case (op)
      1: return data & MASK;
      2, 6: begin
        if (op == 6) f = (cur >> (WIDTH - 1)) & 1;
        if (n >= WIDTH) return f ? MASK : 0;
        return (cur >> n) | (f ? (MASK & ~(MASK >> n)) : 0);
      end
      3: begin
        if (n >= WIDTH) return f ? MASK : 0;
        return ((cur << n) & MASK) | (f ? ((1 << n) - 1) : 0);
      end
      4: begin
        r = n % WIDTH;
        return ((cur >> r) | (cur << (WIDTH - r))) & MASK;
      end
      5: begin
        r = n % WIDTH;
        return ((cur << r) | (cur >> (WIDTH - r))) & MASK;
      end
      default: return cur;
    endcase
  endfunction

  task automatic sendCmd(input int op, input int cnt, input int data, input int fill_v,
                         input bit hold, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    cmd_op    = op[2:0];
    cmd_cnt   = cnt[CNT_W-1:0];
    cmd_data  = data[WIDTH-1:0];
    fill      = fill_v[0];
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = hold;
    cmd_op    = 3'($urandom);
    cmd_cnt   = CNT_W'($urandom);
    cmd_data  = WIDTH'($urandom);
    fill      = 1'($urandom);
  endtask

  task automatic applyStimulus(input int op, input int cnt, input int data,
                               input int fill_v, input bit hold);
    bit ok;
    int exp_q, active, exp_s, done_idx, s_cycles, bad_s, bad_ctl, bad_ser, err_seen;
    bit is_shift;
    exp_q    = refResult(op, cnt, model_q, data, fill_v);
    is_shift = (op >= 2) && (op <= 6);
    active   = (op == 1) ? 1 : ((is_shift && cnt > 0) ? cnt : 0);
    exp_s    = (op == 1) ? 3 : ((op == 3 || op == 5) ? 2 : 1);
    sendCmd(op, cnt, data, fill_v, hold, ok);
    if (!ok) return;
    done_idx = 0; s_cycles = 0; bad_s = 0; bad_ctl = 0; bad_ser = 0; err_seen = 0;
    for (int idx = 1; idx <= 12; idx++) begin
      @(negedge clk);
      if (s != 2'b00) begin
        s_cycles++;
        if (int'(s) != exp_s) bad_s++;
      end
      if (!busy || cmd_ready) bad_ctl++;
      if ((s != 2'b01 && ls) || (s != 2'b10 && rs)) bad_ser++;
      if (done) begin
        done_idx = idx;
        err_seen = int'(err);
        break;
      end
      if (err) bad_ctl++;
    end
    checkOutput("done_latency", done_idx, active + 1);
    checkOutput("err_flag", err_seen, (op == 7) ? 1 : 0);
    checkOutput("s_active_cycles", s_cycles, active);
    checkOutput("s_mode", bad_s, 0);
    checkOutput("busy_ready", bad_ctl, 0);
    checkOutput("serial_side", bad_ser, 0);
    checkOutput("a_latched", int'(a), data & MASK);
    checkOutput("q_result", int'(usr_q), exp_q);
    @(negedge clk);
    checkOutput("idle_after", int'({done, busy, cmd_ready}), 1);
    if (hold) cmd_valid = 1'b0;
    model_q = exp_q;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    bit saw_done;
    repeat (3) @(negedge clk);
    checkOutput("rst_s", int'(s), 0);
    checkOutput("rst_a", int'(a), 0);
    checkOutput("rst_ctl", int'({busy, done, err, cmd_ready, rs, ls}), 0);
    rst = 1'b0;

    // Directed sequence from the test plan.
    applyStimulus(1, 0, 4'b1011, 0, 1'b0);
    applyStimulus(4, 1, 0, 0, 1'b0);
    applyStimulus(5, 4, 0, 0, 1'b0);
    applyStimulus(1, 0, 4'b1000, 0, 1'b0);
    applyStimulus(6, 2, 4'b1000, 0, 1'b0);
    applyStimulus(1, 0, 4'b0110, 0, 1'b0);
    applyStimulus(2, 3, 4'b0110, 0, 1'b0);
    applyStimulus(3, 2, 0, 1, 1'b0);
    applyStimulus(7, 3, 4'b0101, 1, 1'b0);
    applyStimulus(2, 0, 4'b1111, 1, 1'b0);
    applyStimulus(3, 3, 4'b1001, 0, 1'b1);
    applyStimulus(0, 5, 4'b0011, 1, 1'b1);

    // Reset in the second active cycle of an SHR by 5: only one shift lands.
    sendCmd(2, 5, 4'b1001, 1, 1'b0, ok);
    if (ok) begin
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst_s", int'(s), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      saw_done = 1'b0;
      repeat (3) begin
        @(negedge clk);
        saw_done |= done;
      end
      rst = 1'b0;
      checkOutput("midrst_done", int'(saw_done), 0);
      model_q = refResult(2, 1, model_q, 0, 1);
      checkOutput("midrst_q", int'(usr_q), model_q);
    end
    applyStimulus(4, 7, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(MASK, 0),
                    $urandom_range(1, 0), ($urandom_range(3, 0) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
